// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: byte FIFO feeding an MSB-first serializer with comma sync preamble.
// Optional idle-comma counter output idle_cnt enabled by defining SERIAL_TX_IDLE_CNT_EN.
module paralelo_serial_tx #(
    parameter logic [7:0] COMMA       = 8'hBC,
    parameter int         SYNC_COMMAS = 4,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic                          clk_32f,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          data_out,
    output logic                          byte_start,
    output logic                          tx_active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef SERIAL_TX_IDLE_CNT_EN
    ,
    output logic [15:0]                   idle_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(SYNC_COMMAS + 1);

    localparam logic [0:0] SYNC   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
    logic [0:0]    state;
    logic [SW-1:0] sync_cnt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic       load;
    logic       sync_done;
    logic       go_active;
    logic       push;
    logic       pop;
    logic [7:0] next_byte;

    // A byte slot starts whenever the bit counter wraps.
    assign load      = (bit_cnt == 3'd7);
    assign sync_done = (sync_cnt >= SW'(SYNC_COMMAS));
    // Active loading also covers the edge that ends the preamble.
    assign go_active = load && ((state == ACTIVE) || sync_done);
    assign pop       = go_active && (fifo_level != '0);
    assign push      = valid_in && ready_out;
    assign ready_out = (fifo_level < LW'(FIFO_DEPTH));
    assign data_out  = shift_reg[7];
    assign next_byte = pop ? mem[rd_ptr] : COMMA;

    // Bit counter, serializer and preamble sequencing
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= 3'd7;
            shift_reg  <= 8'hFF;
            byte_start <= 1'b0;
            state      <= SYNC;
            tx_active  <= 1'b0;
            sync_cnt   <= '0;
        end else begin
            bit_cnt    <= bit_cnt + 3'd1;
            byte_start <= load;
            if (load) begin
                shift_reg <= next_byte;
                if (go_active) begin
                    state     <= ACTIVE;
                    tx_active <= 1'b1;
                end else begin
                    sync_cnt <= sync_cnt + SW'(1);
                end
            end else begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
        end
    end

    // FIFO pointers and occupancy; power-of-2 depth wraps naturally
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while level is zero
    always_ff @(posedge clk_32f) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef SERIAL_TX_IDLE_CNT_EN
    // Count idle fill commas after the preamble, saturating
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (go_active && !pop && (idle_cnt != 16'hFFFF)) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: slot-level reference model plus directed and random stimulus.
// Build with SERIAL_TX_IDLE_CNT_EN defined to also check idle_cnt.
module tb_paralelo_serial_tx;

    localparam int         DEPTH = 4;
    localparam int         NSYNC = 4;
    localparam logic [7:0] CM    = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       byte_start;
    logic       tx_active;
    logic [2:0] fifo_level;
`ifdef SERIAL_TX_IDLE_CNT_EN
    logic [15:0] idle_cnt;
`endif

    paralelo_serial_tx dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .byte_start (byte_start),
        .tx_active  (tx_active),
        .fifo_level (fifo_level)
`ifdef SERIAL_TX_IDLE_CNT_EN
        ,
        .idle_cnt   (idle_cnt)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    // Reference model: the wire is a sequence of 8-bit slots.
    // Slot k < NSYNC is a comma; later slots take the queue head or a comma.
    logic [7:0]  m_q[$];
    int          m_n = 0;
    logic [7:0]  m_cur = 8'hFF;
    logic [2:0]  m_pos = 3'd0;
    logic        m_bs = 1'b0;
    logic        m_tx = 1'b0;
    logic [15:0] m_idle = 16'd0;
    logic        m_rdy;

    always @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_n    = 0;
            m_cur  = 8'hFF;
            m_pos  = 3'd0;
            m_bs   = 1'b0;
            m_tx   = 1'b0;
            m_idle = 16'd0;
        end else begin
            m_rdy = (m_q.size() < DEPTH);
            if (m_n % 8 == 0) begin
                if (m_n / 8 < NSYNC) begin
                    m_cur = CM;
                end else begin
                    m_tx = 1'b1;
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front();
                    end else begin
                        m_cur = CM;
                        if (m_idle != 16'hFFFF) m_idle = m_idle + 16'd1;
                    end
                end
                m_pos = 3'd0;
                m_bs  = 1'b1;
            end else begin
                m_pos = m_pos + 3'd1;
                m_bs  = 1'b0;
            end
            if (valid_in && m_rdy) m_q.push_back(data_in);
            m_n = m_n + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_bs(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_32f);
            if (byte_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic get_byte(output logic [7:0] b, output bit ok);
        b = 8'h00;
        wait_bs(ok);
        if (ok) begin
            b[7] = data_out;
            for (int i = 6; i >= 0; i--) begin
                @(negedge clk_32f);
                b[i] = data_out;
            end
        end
    endtask

    task automatic release_seq(input bit with_data);
        logic [71:0] got;
        logic [71:0] want;
        got  = '0;
        want = with_data ? {CM, CM, CM, CM, 8'hA5, 8'h3C, CM, CM, CM}
                         : {9{CM}};
        reset    = 1'b1;
        valid_in = with_data;
        data_in  = 8'hA5;
        for (int i = 1; i <= 72; i++) begin
            @(negedge clk_32f);
            got[72-i] = data_out;
            if (i == 1) begin
                chk("bs_first", {15'd0, byte_start}, 16'd1);
                data_in = 8'h3C;
            end
            if (i == 2) valid_in = 1'b0;
            if (i == 9 || i == 17 || i == 25)
                chk("bs_sync", {15'd0, byte_start}, 16'd1);
            if (i == 5) chk("bs_mid", {15'd0, byte_start}, 16'd0);
            if (i == 32) chk("tx_pre", {15'd0, tx_active}, 16'd0);
            if (i == 33) chk("tx_post", {15'd0, tx_active}, 16'd1);
`ifdef SERIAL_TX_IDLE_CNT_EN
            if (i == 1) chk("idle_zero", idle_cnt, 16'd0);
            if (i == 72) chk("idle_n", idle_cnt, with_data ? 16'd3 : 16'd5);
`endif
        end
        for (int b = 0; b < 9; b++)
            chk("stream", {8'd0, got[71-8*b -: 8]}, {8'd0, want[71-8*b -: 8]});
    endtask

    logic [7:0] b;
    bit         ok;

    initial begin
        fork
            forever begin
                @(negedge clk_32f);
                chk("data_out", {15'd0, data_out}, {15'd0, m_cur[3'd7-m_pos]});
                chk("byte_start", {15'd0, byte_start}, {15'd0, m_bs});
                chk("tx_active", {15'd0, tx_active}, {15'd0, m_tx});
                chk("fifo_level", {13'd0, fifo_level}, 16'(m_q.size()));
                chk("ready_out", {15'd0, ready_out}, {15'd0, m_q.size() < DEPTH});
`ifdef SERIAL_TX_IDLE_CNT_EN
                chk("idle_cnt", idle_cnt, m_idle);
`endif
            end
        join_none

        repeat (3) @(negedge clk_32f);
        chk("rst_dout", {15'd0, data_out}, 16'd1);
        chk("rst_ready", {15'd0, ready_out}, 16'd1);
        chk("rst_level", {13'd0, fifo_level}, 16'd0);

        // Preamble with no data
        release_seq(1'b0);

        // Single byte into empty FIFO
        valid_in = 1'b1;
        data_in  = 8'h5A;
        @(negedge clk_32f);
        valid_in = 1'b0;
        chk("lvl_one", {13'd0, fifo_level}, 16'd1);
        get_byte(b, ok);
        chk("to_5a", {15'd0, ok}, 16'd1);
        chk("byte_5a", {8'd0, b}, 16'h005A);
        chk("lvl_zero", {13'd0, fifo_level}, 16'd0);
        get_byte(b, ok);
        chk("after_5a", {8'd0, b}, {8'd0, CM});

        // Back-to-back writes right after a load edge
        repeat (16) @(negedge clk_32f);
        wait_bs(ok);
        chk("to_bb", {15'd0, ok}, 16'd1);
        for (int i = 1; i <= 6; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(i);
            @(negedge clk_32f);
        end
        valid_in = 1'b0;
        chk("bb_full", {13'd0, fifo_level}, 16'd4);
        chk("bb_ready", {15'd0, ready_out}, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            get_byte(b, ok);
            chk("bb_byte", {8'd0, b}, 16'(i));
        end
        get_byte(b, ok);
        chk("bb_tail", {8'd0, b}, {8'd0, CM});

        // Full FIFO with valid held across a load edge
        repeat (16) @(negedge clk_32f);
        wait_bs(ok);
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            data_in  = (i < 4) ? 8'(8'h10 + i) : 8'h77;
            @(negedge clk_32f);
        end
        chk("full_pop_lvl", {13'd0, fifo_level}, 16'd3);
        chk("full_pop_rdy", {15'd0, ready_out}, 16'd1);
        valid_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            get_byte(b, ok);
            chk("full_byte", {8'd0, b}, 16'(8'h10 + i));
        end

        // Reset while 0xF0 is in flight with two bytes queued
        repeat (16) @(negedge clk_32f);
        wait_bs(ok);
        valid_in = 1'b1;
        data_in  = 8'hF0;
        @(negedge clk_32f);
        data_in = 8'h3F;
        @(negedge clk_32f);
        data_in = 8'h81;
        @(negedge clk_32f);
        valid_in = 1'b0;
        wait_bs(ok);
        chk("f0_queued", {13'd0, fifo_level}, 16'd2);
        repeat (2) @(negedge clk_32f);
        #2 reset = 1'b0;
        #1;
        chk("arst_dout", {15'd0, data_out}, 16'd1);
        chk("arst_level", {13'd0, fifo_level}, 16'd0);
        chk("arst_tx", {15'd0, tx_active}, 16'd0);
        repeat (2) @(negedge clk_32f);

        // Writes during the resent preamble
        release_seq(1'b1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            valid_in = ($urandom_range(0, 5) == 0);
            data_in  = 8'($urandom_range(0, 255));
            @(negedge clk_32f);
        end
        valid_in = 1'b0;
        repeat (50) @(negedge clk_32f);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
